// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one RAM write port and one RAM read port between clients A and B.
// Optional macro COLLISION_STALL_EN: a read that targets the address being written in the same cycle waits one cycle.
module ram_access_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wreq_a,
    input  logic              wreq_b,
    input  logic [ADDR_W-1:0] waddr_a,
    input  logic [ADDR_W-1:0] waddr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              wgnt_a,
    output logic              wgnt_b,
    input  logic              rreq_a,
    input  logic              rreq_b,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic              rgnt_a,
    output logic              rgnt_b,
    output logic              rvld_a,
    output logic              rvld_b,
    output logic [DATA_W-1:0] rdata,
    output logic              wr_enb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_enb,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);

    typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_e;

    // Client that wins the next contention on each port.
    sel_e r_wptr;
    sel_e r_rptr;

    logic              w_wgnt_a;
    logic              w_wgnt_b;
    logic              w_rwin_a;
    logic              w_rwin_b;
    logic              w_rgnt_a;
    logic              w_rgnt_b;
    logic              w_wany;
    logic              w_rany;
    logic              w_rstall;
    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_wdata;

    logic              r_wr_enb;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_rd_enb;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [RD_LAT-1:0] r_pvld;
    logic [RD_LAT-1:0] r_ptag;
    logic              r_rvld_a;
    logic              r_rvld_b;
    logic [DATA_W-1:0] r_rdata;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_wgnt_a = 1'b0;
        w_wgnt_b = 1'b0;
        w_rwin_a = 1'b0;
        w_rwin_b = 1'b0;
        if (wreq_a && (!wreq_b || r_wptr == SEL_A)) w_wgnt_a = 1'b1;
        else if (wreq_b)                            w_wgnt_b = 1'b1;
        if (rreq_a && (!rreq_b || r_rptr == SEL_A)) w_rwin_a = 1'b1;
        else if (rreq_b)                            w_rwin_b = 1'b1;
    end

    assign w_wany  = w_wgnt_a | w_wgnt_b;
    assign w_waddr = w_wgnt_b ? waddr_b : waddr_a;
    assign w_wdata = w_wgnt_b ? wdata_b : wdata_a;
    assign w_raddr = w_rwin_b ? raddr_b : raddr_a;

`ifdef COLLISION_STALL_EN
    // Holding the read back one cycle makes it observe the data being written now.
    assign w_rstall = w_wany & (w_rwin_a | w_rwin_b) & (w_waddr == w_raddr);
`else
    assign w_rstall = 1'b0;
`endif

    assign w_rgnt_a = w_rwin_a & ~w_rstall;
    assign w_rgnt_b = w_rwin_b & ~w_rstall;
    assign w_rany   = w_rgnt_a | w_rgnt_b;

    // Grants are forced low while reset is held so every output reads 0 during reset.
    assign wgnt_a = w_wgnt_a & rst;
    assign wgnt_b = w_wgnt_b & rst;
    assign rgnt_a = w_rgnt_a & rst;
    assign rgnt_b = w_rgnt_b & rst;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr    <= SEL_A;
            r_rptr    <= SEL_A;
            r_wr_enb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_enb  <= 1'b0;
            r_rd_addr <= '0;
            r_pvld    <= '0;
            r_ptag    <= '0;
            r_rvld_a  <= 1'b0;
            r_rvld_b  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_wgnt_a)      r_wptr <= SEL_B;
            else if (w_wgnt_b) r_wptr <= SEL_A;
            if (w_rgnt_a)      r_rptr <= SEL_B;
            else if (w_rgnt_b) r_rptr <= SEL_A;

            r_wr_enb  <= w_wany;
            r_wr_addr <= w_wany ? w_waddr : '0;
            r_wr_data <= w_wany ? w_wdata : '0;
            r_rd_enb  <= w_rany;
            r_rd_addr <= w_rany ? w_raddr : '0;

            // Tag stage 0 rides alongside rd_enb; the last stage becomes the rvld pulse.
            r_pvld[0] <= w_rany;
            r_ptag[0] <= w_rgnt_b;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pvld[i] <= r_pvld[i-1];
                r_ptag[i] <= r_ptag[i-1];
            end
            r_rvld_a <= r_pvld[RD_LAT-1] & ~r_ptag[RD_LAT-1];
            r_rvld_b <= r_pvld[RD_LAT-1] &  r_ptag[RD_LAT-1];
            if (r_pvld[RD_LAT-1]) r_rdata <= rd_data;
        end
    end

    assign wr_enb  = r_wr_enb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_enb  = r_rd_enb;
    assign rd_addr = r_rd_addr;
    assign rvld_a  = r_rvld_a;
    assign rvld_b  = r_rvld_b;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: directed scenarios then random client traffic, checked against a
// transaction-level model (RR by "last granted", memory array, queue of expected read returns).
module tb_ram_access_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              wreq_a, wreq_b, rreq_a, rreq_b;
    logic [ADDR_W-1:0] waddr_a, waddr_b, raddr_a, raddr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic              wgnt_a, wgnt_b, rgnt_a, rgnt_b, rvld_a, rvld_b;
    logic [DATA_W-1:0] rdata;
    logic              wr_enb, rd_enb;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data, rd_data;

    ram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .wreq_a(wreq_a), .wreq_b(wreq_b), .waddr_a(waddr_a), .waddr_b(waddr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b), .wgnt_a(wgnt_a), .wgnt_b(wgnt_b),
        .rreq_a(rreq_a), .rreq_b(rreq_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rgnt_a(rgnt_a), .rgnt_b(rgnt_b), .rvld_a(rvld_a), .rvld_b(rvld_b), .rdata(rdata),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // External RAM: writes commit at the edge that samples wr_enb; read data follows rd_addr (RD_LAT=1).
    logic [DATA_W-1:0] ram [16];
    always @(posedge clk) if (wr_enb) ram[wr_addr] <= wr_data;
    assign rd_data = ram[rd_addr];

    typedef struct {
        int              due;
        bit              tag_b;
        logic [DATA_W-1:0] data;
        bit              dc;
    } ret_t;

    int                n_checks, n_errors, cyc;
    bit                m_wlast_b, m_rlast_b;
    logic [DATA_W-1:0] m_mem [16];
    ret_t              rq [$];
    bit                g_wa, g_wb, g_ra, g_rb;
    logic              e_wr_enb, e_rd_enb;
    logic [ADDR_W-1:0] e_wr_addr, e_rd_addr;
    logic [DATA_W-1:0] e_wr_data, e_rdata;
    bit                e_known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void pick(input bit req_a, input bit req_b, input bit last_b,
                                 output bit ga, output bit gb);
        ga = 1'b0;
        gb = 1'b0;
        if (req_a && req_b) begin
            if (last_b) ga = 1'b1;
            else        gb = 1'b1;
        end else if (req_a) ga = 1'b1;
        else if (req_b)     gb = 1'b1;
    endfunction

    task automatic model_reset();
        m_wlast_b = 1'b1;
        m_rlast_b = 1'b1;
        rq.delete();
        e_wr_enb = 0; e_wr_addr = 0; e_wr_data = 0;
        e_rd_enb = 0; e_rd_addr = 0;
        e_rdata  = 0; e_known = 1'b1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_wgnt_a"}, wgnt_a, 0);
        check({pfx, "_wgnt_b"}, wgnt_b, 0);
        check({pfx, "_rgnt_a"}, rgnt_a, 0);
        check({pfx, "_rgnt_b"}, rgnt_b, 0);
        check({pfx, "_rvld_a"}, rvld_a, 0);
        check({pfx, "_rvld_b"}, rvld_b, 0);
        check({pfx, "_rdata"},  rdata,  0);
        check({pfx, "_wr_enb"}, wr_enb, 0);
        check({pfx, "_wr_addr"}, wr_addr, 0);
        check({pfx, "_wr_data"}, wr_data, 0);
        check({pfx, "_rd_enb"}, rd_enb, 0);
        check({pfx, "_rd_addr"}, rd_addr, 0);
    endtask

    // One clock cycle: check grants mid-cycle, predict the edge, then check registered outputs.
    task automatic step();
        bit                wa, wb, ra, rb, dc;
        logic [ADDR_W-1:0] wad, rad;
        ret_t              r;
        #2;
        pick(wreq_a, wreq_b, m_wlast_b, wa, wb);
        pick(rreq_a, rreq_b, m_rlast_b, ra, rb);
        wad = wb ? waddr_b : waddr_a;
        rad = rb ? raddr_b : raddr_a;
        dc  = 1'b0;
        if ((wa || wb) && (ra || rb) && wad == rad) begin
`ifdef COLLISION_STALL_EN
            ra = 1'b0;
            rb = 1'b0;
`else
            dc = 1'b1;
`endif
        end
        check("wgnt_a", wgnt_a, wa);
        check("wgnt_b", wgnt_b, wb);
        check("rgnt_a", rgnt_a, ra);
        check("rgnt_b", rgnt_b, rb);

        e_wr_enb  = wa || wb;
        e_wr_addr = (wa || wb) ? wad : '0;
        e_wr_data = wa ? wdata_a : (wb ? wdata_b : '0);
        e_rd_enb  = ra || rb;
        e_rd_addr = (ra || rb) ? rad : '0;
        if (ra || rb) rq.push_back('{due: cyc + 1 + RD_LAT, tag_b: rb, data: m_mem[rad], dc: dc});
        if (wa) m_wlast_b = 1'b0;
        if (wb) m_wlast_b = 1'b1;
        if (ra) m_rlast_b = 1'b0;
        if (rb) m_rlast_b = 1'b1;
        if (wa || wb) m_mem[wad] = e_wr_data;
        g_wa = wa; g_wb = wb; g_ra = ra; g_rb = rb;

        @(posedge clk);
        #1;
        cyc++;
        check("wr_enb",  wr_enb,  e_wr_enb);
        check("wr_addr", wr_addr, e_wr_addr);
        check("wr_data", wr_data, e_wr_data);
        check("rd_enb",  rd_enb,  e_rd_enb);
        check("rd_addr", rd_addr, e_rd_addr);
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            check("rvld_a", rvld_a, !r.tag_b);
            check("rvld_b", rvld_b, r.tag_b);
            if (r.dc) e_known = 1'b0;
            else begin
                e_known = 1'b1;
                e_rdata = r.data;
            end
        end else begin
            check("rvld_a_idle", rvld_a, 0);
            check("rvld_b_idle", rvld_b, 0);
        end
        if (e_known) check("rdata", rdata, e_rdata);
    endtask

    task automatic release_granted();
        if (g_wa) wreq_a = 1'b0;
        if (g_wb) wreq_b = 1'b0;
        if (g_ra) rreq_a = 1'b0;
        if (g_rb) rreq_b = 1'b0;
    endtask

    // Random address avoiding the other port's active addresses, so no same-cycle collisions occur.
    function automatic logic [ADDR_W-1:0] new_addr(input bit v0, input logic [ADDR_W-1:0] a0,
                                                   input bit v1, input logic [ADDR_W-1:0] a1);
        logic [ADDR_W-1:0] a;
        do a = ADDR_W'($urandom_range(0, 15));
        while ((v0 && a == a0) || (v1 && a == a1));
        return a;
    endfunction

    task automatic rand_clients();
        if (!wreq_a || g_wa) begin
            wreq_a = ($urandom_range(0, 3) != 0);
            if (wreq_a) begin
                waddr_a = new_addr(rreq_a, raddr_a, rreq_b, raddr_b);
                wdata_a = DATA_W'($urandom);
            end
        end else if ($urandom_range(0, 7) == 0) wreq_a = 1'b0;
        if (!wreq_b || g_wb) begin
            wreq_b = ($urandom_range(0, 3) != 0);
            if (wreq_b) begin
                waddr_b = new_addr(rreq_a, raddr_a, rreq_b, raddr_b);
                wdata_b = DATA_W'($urandom);
            end
        end else if ($urandom_range(0, 7) == 0) wreq_b = 1'b0;
        if (!rreq_a || g_ra) begin
            rreq_a = ($urandom_range(0, 3) != 0);
            if (rreq_a) raddr_a = new_addr(wreq_a, waddr_a, wreq_b, waddr_b);
        end else if ($urandom_range(0, 7) == 0) rreq_a = 1'b0;
        if (!rreq_b || g_rb) begin
            rreq_b = ($urandom_range(0, 3) != 0);
            if (rreq_b) raddr_b = new_addr(wreq_a, waddr_a, wreq_b, waddr_b);
        end else if ($urandom_range(0, 7) == 0) rreq_b = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        for (int i = 0; i < 16; i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        rst = 1'b0;
        wreq_a = 0; wreq_b = 0; rreq_a = 0; rreq_b = 0;
        waddr_a = 0; waddr_b = 0; raddr_a = 0; raddr_b = 0;
        wdata_a = 0; wdata_b = 0;
        g_wa = 0; g_wb = 0; g_ra = 0; g_rb = 0;
        model_reset();
        #1;
        check_all_zero("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Write contention: A and B held four cycles, grants alternate starting with A.
        wreq_a = 1; waddr_a = 4'd1; wdata_a = 8'h11;
        wreq_b = 1; waddr_b = 4'd2; wdata_b = 8'h22;
        repeat (4) step();
        wreq_a = 0; wreq_b = 0;
        step();

        // Single write 0xA5 to address 3, one-cycle command on the RAM port.
        wreq_a = 1; waddr_a = 4'd3; wdata_a = 8'hA5;
        step();
        wreq_a = 0;
        repeat (2) step();

        // Single read by B of address 3.
        rreq_b = 1; raddr_b = 4'd3;
        step();
        rreq_b = 0;
        repeat (3) step();

        // Back-to-back reads from both clients.
        rreq_a = 1; raddr_a = 4'd1;
        rreq_b = 1; raddr_b = 4'd2;
        repeat (8) step();
        rreq_a = 0; rreq_b = 0;
        repeat (3) step();

        // Same-cycle write and read of address 5.
        wreq_a = 1; waddr_a = 4'd5; wdata_a = 8'h3C;
        rreq_a = 1; raddr_a = 4'd5;
        step();
        release_granted();
        step();
        release_granted();
        repeat (4) step();

        // Random traffic.
        repeat (400) begin
            rand_clients();
            step();
        end

        // Reset asserted with reads in flight.
        wreq_a = 0; wreq_b = 0;
        rreq_a = 1; raddr_a = ADDR_W'($urandom_range(0, 15));
        rreq_b = 1; raddr_b = ADDR_W'($urandom_range(0, 15));
        repeat (2) step();
        rreq_a = 0; rreq_b = 0;
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) step();

        // First contention after reset favours A on both ports.
        wreq_a = 1; waddr_a = 4'd6; wdata_a = 8'h66;
        wreq_b = 1; waddr_b = 4'd7; wdata_b = 8'h77;
        rreq_a = 1; raddr_a = 4'd8;
        rreq_b = 1; raddr_b = 4'd9;
        step();
        release_granted();
        step();
        release_granted();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single write port and single read port of the 16x8 RAM between two clients, A and B.
- Round-robin arbitration is independent per port. Grants are combinational.
- RAM-side commands are registered. Read data is routed back to the issuing client with a valid pulse, tracked through a latency pipeline.
- Sits between the client logic and the RAM's wr_*/rd_* pins.

Parameters:
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width
- RD_LAT, 1, cycles from RAM rd_enb sampled to rd_data valid (range 1..4)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- wreq_a / wreq_b  in  1  write request, held until granted
- waddr_a / waddr_b  in  ADDR_W  write address
- wdata_a / wdata_b  in  DATA_W  write data
- wgnt_a / wgnt_b  out  1  write grant (combinational); command accepted at this edge
- rreq_a / rreq_b  in  1  read request, held until granted
- raddr_a / raddr_b  in  ADDR_W  read address
- rgnt_a / rgnt_b  out  1  read grant (combinational)
- rvld_a / rvld_b  out  1  read data valid for that client, 1-cycle pulse
- rdata  out  DATA_W  returned read data, shared by both clients
- wr_enb, wr_addr, wr_data  out  1/ADDR_W/DATA_W  RAM write port, registered
- rd_enb, rd_addr  out  1/ADDR_W  RAM read port, registered
- rd_data  in  DATA_W  RAM read data

Behaviour:
- Reset (rst=0, async):
  - All outputs go to 0.
  - Both round-robin pointers select A.
  - Read-tag pipeline is flushed; in-flight reads produce no rvld.
  - Reset asserted mid-operation drops accepted-but-unreturned reads silently.
- Per-port arbitration is identical for the write and read ports.
  - Only one requester asserting: it is granted that cycle.
  - Both asserting: grant the one not granted most recently. The pointer toggles only on a grant.
  - Never more than one grant per port per cycle. Grants are 0 when there is no request.
- Handshake:
  - Client holds req/addr/data stable until the edge where gnt=1.
  - Client may keep req high for back-to-back accesses.
  - req dropping without a grant is legal; no state is left behind.
- Issue timing: a grant in cycle N drives RAM wr_enb/wr_addr/wr_data (or rd_enb/rd_addr) in cycle N+1 for exactly one cycle. These are 0 when no grant.
- Read return:
  - A 1-bit client tag and a valid bit shift through an (RD_LAT+1)-deep pipeline.
  - Read granted in cycle N: rdata = rd_data and rvld_<tag>=1 in cycle N+1+RD_LAT. rdata is registered from rd_data.
  - rdata holds its last value otherwise.
- Throughput: 1 write and 1 read per cycle, sustained. Fully pipelined, no bubbles.
- The write and read ports never block each other, except under the optional feature.
- Address width: no wrap or range checks; addresses pass through unchanged.

Optional Feature:
- Macro: COLLISION_STALL_EN.
- When defined: in a cycle where both ports have a winner and winning raddr == winning waddr:
  - The write is granted.
  - The read grant is withheld; its RR pointer is unchanged.
  - The read wins next cycle if still requested, so it returns the newly written data.
- When not defined: both are granted. The returned data for a same-cycle, same-address collision is whatever the RAM produces and is not checked.

Test Plan:
- Reset: rst=0 mid-stream with reads in flight -> all outputs 0 immediately; no rvld after rst=1; first contention grants A.
- Single write: wreq_a, addr 3, data 0xA5 -> wgnt_a same cycle; next cycle wr_enb=1, wr_addr=3, wr_data=0xA5, lasting one cycle.
- Write contention: wreq_a and wreq_b held 4 cycles -> grants alternate A,B,A,B; each write appears on the RAM port the following cycle.
- Read return, RD_LAT=1: rreq_b, addr 3 after 0xA5 is written -> rgnt_b cycle N; rd_enb at N+1; rvld_b=1 and rdata=0xA5 at N+2; rvld_a stays 0.
- Pipelined reads: rreq_a and rreq_b continuously, addrs 1 (0x11) and 2 (0x22) -> rvld alternates A/B every cycle with rdata 0x11/0x22; no gaps.
- Collision, COLLISION_STALL_EN defined: wreq_a addr 5 data 0x3C and rreq_a addr 5 in the same cycle, old value 0x00 -> write granted, read granted one cycle later, returned rdata=0x3C.
